// File: rtl/cla_adder_reg.sv
// Registered carry-lookahead adder built from 4-bit lookahead groups.
// A second lookahead level across the groups produces the group carry-ins and the block P/G.
module cla_adder_reg #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             grp_p,
    output logic             grp_g,
    output logic             out_valid
);

    localparam int unsigned NG = WIDTH / 4;

    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] sum_next;
    logic [NG-1:0]    gp;
    logic [NG-1:0]    gg;
    logic [NG-1:0]    gcin;
    logic             top_p;
    logic             top_g;
    logic             carry_next;
    logic             term;
    logic             prod;

    assign p = a ^ b;
    assign g = a & b;

    for (genvar k = 0; k < NG; k++) begin : g_grp
        logic [3:0] pk;
        logic [3:0] gk;
        logic       c0;

        assign pk = p[4*k +: 4];
        assign gk = g[4*k +: 4];
        assign c0 = gcin[k];

        // Every carry is a flat sum of products on the group carry-in, never a ripple.
        assign c[4*k]   = c0;
        assign c[4*k+1] = gk[0] | (pk[0] & c0);
        assign c[4*k+2] = gk[1] | (pk[1] & gk[0]) | (pk[1] & pk[0] & c0);
        assign c[4*k+3] = gk[2] | (pk[2] & gk[1]) | (pk[2] & pk[1] & gk[0])
                        | (pk[2] & pk[1] & pk[0] & c0);

        assign gp[k] = &pk;
        assign gg[k] = gk[3] | (pk[3] & gk[2]) | (pk[3] & pk[2] & gk[1])
                     | (pk[3] & pk[2] & pk[1] & gk[0]);
    end

    // Second level: group k carry-in expanded as OR over j<k of G[j]*P[j+1..k-1], plus P[0..k-1]*cin.
    always_comb begin
        gcin  = '0;
        top_p = 1'b1;
        top_g = 1'b0;
        term  = 1'b0;
        prod  = 1'b0;
        for (int unsigned k = 0; k < NG; k++) begin
            term = 1'b0;
            for (int unsigned j = 0; j < k; j++) begin
                prod = gg[j];
                for (int unsigned m = j + 1; m < k; m++) begin
                    prod = prod & gp[m];
                end
                term = term | prod;
            end
            prod = cin;
            for (int unsigned m = 0; m < k; m++) begin
                prod = prod & gp[m];
            end
            gcin[k] = term | prod;
        end
        top_p = &gp;
        for (int unsigned j = 0; j < NG; j++) begin
            prod = gg[j];
            for (int unsigned m = j + 1; m < NG; m++) begin
                prod = prod & gp[m];
            end
            top_g = top_g | prod;
        end
    end

    assign carry_next = top_g | (top_p & cin);
    assign sum_next   = p ^ c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum       <= '0;
            carry     <= 1'b0;
            grp_p     <= 1'b0;
            grp_g     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum   <= sum_next;
                carry <= carry_next;
                grp_p <= top_p;
                grp_g <= top_g;
            end
        end
    end

endmodule

// File: tb/tb_cla_adder_reg.sv
// Self-checking bench for cla_adder_reg at WIDTH=4 and WIDTH=16 against an arithmetic model.
module tb_cla_adder_reg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid4 = 1'b0;
    logic [3:0]  a4 = '0;
    logic [3:0]  b4 = '0;
    logic        cin4 = 1'b0;
    logic [3:0]  sum4;
    logic        carry4, grp_p4, grp_g4, out_valid4;

    logic        in_valid16 = 1'b0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        cin16 = 1'b0;
    logic [15:0] sum16;
    logic        carry16, grp_p16, grp_g16, out_valid16;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cla_adder_reg #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .a(a4), .b(b4), .cin(cin4),
        .sum(sum4), .carry(carry4), .grp_p(grp_p4), .grp_g(grp_g4), .out_valid(out_valid4)
    );

    cla_adder_reg #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .a(a16), .b(b16), .cin(cin16),
        .sum(sum16), .carry(carry16), .grp_p(grp_p16), .grp_g(grp_g16), .out_valid(out_valid16)
    );

    // Model result packed as {grp_p, grp_g, carry, sum}.
    // P: a carry-in travels through the whole block exactly when a+b is all ones.
    // G: the block overflows on its own, i.e. a+b with no carry-in exceeds the range.
    function automatic logic [6:0] ref4(input logic [3:0] x, input logic [3:0] y, input logic ci);
        int unsigned s;
        int unsigned s0;
        s0 = int'(x) + int'(y);
        s  = s0 + int'(ci);
        return {s0 == 15, s0 > 15, s[4:0]};
    endfunction

    function automatic logic [18:0] ref16(input logic [15:0] x, input logic [15:0] y, input logic ci);
        int unsigned s;
        int unsigned s0;
        s0 = int'(x) + int'(y);
        s  = s0 + int'(ci);
        return {s0 == 65535, s0 > 65535, s[16:0]};
    endfunction

    task automatic test_reset;
        a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1; in_valid4 = 1'b1;
        a16 = 16'hFFFF; b16 = 16'h1234; cin16 = 1'b1; in_valid16 = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid4, grp_p4, grp_g4, carry4, sum4} !== 8'h00) begin
            errors++;
            $display("FAIL reset_w4: got %h expected 00", {out_valid4, grp_p4, grp_g4, carry4, sum4});
        end
        checks++;
        if ({out_valid16, grp_p16, grp_g16, carry16, sum16} !== 20'h0) begin
            errors++;
            $display("FAIL reset_w16: got %h expected 00000", {out_valid16, grp_p16, grp_g16, carry16, sum16});
        end
        in_valid4 = 1'b0; in_valid16 = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        logic [3:0] va [0:9];
        logic [3:0] vb [0:9];
        logic       vc [0:9];
        logic [7:0] exp;
        va = '{4'h1, 4'h2, 4'h3, 4'h1, 4'hB, 4'h8, 4'hA, 4'h5, 4'hF, 4'hF};
        vb = '{4'h0, 4'h4, 4'h3, 4'h1, 4'h6, 4'h9, 4'hC, 4'h3, 4'h0, 4'h1};
        vc = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 10; i++) begin
            a4 = va[i]; b4 = vb[i]; cin4 = vc[i]; in_valid4 = 1'b1;
            @(posedge clk);
            #1;
            exp = {1'b1, ref4(va[i], vb[i], vc[i])};
            checks++;
            if ({out_valid4, grp_p4, grp_g4, carry4, sum4} !== exp) begin
                errors++;
                $display("FAIL basic[%0d] a=%h b=%h cin=%b: got %h expected %h",
                         i, va[i], vb[i], vc[i], {out_valid4, grp_p4, grp_g4, carry4, sum4}, exp);
            end
        end
        in_valid4 = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [3:0] x;
        logic [3:0] y;
        logic       ci;
        logic [7:0] exp;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid4 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: out_valid got %b expected 0", out_valid4);
        end
        for (int i = 0; i < 3; i++) begin
            x = 4'($urandom); y = 4'($urandom); ci = 1'($urandom);
            a4 = x; b4 = y; cin4 = ci; in_valid4 = 1'b1;
            @(posedge clk);
            #1;
            exp = {1'b1, ref4(x, y, ci)};
            checks++;
            if ({out_valid4, grp_p4, grp_g4, carry4, sum4} !== exp) begin
                errors++;
                $display("FAIL b2b[%0d]: got %h expected %h", i, {out_valid4, grp_p4, grp_g4, carry4, sum4}, exp);
            end
        end
        in_valid4 = 1'b0;
    endtask

    task automatic test_hold;
        logic [7:0] exp;
        a4 = 4'h9; b4 = 4'h9; cin4 = 1'b1; in_valid4 = 1'b1;
        @(posedge clk);
        #1;
        exp = {1'b1, ref4(4'h9, 4'h9, 1'b1)};
        checks++;
        if ({out_valid4, grp_p4, grp_g4, carry4, sum4} !== exp) begin
            errors++;
            $display("FAIL hold_load: got %h expected %h", {out_valid4, grp_p4, grp_g4, carry4, sum4}, exp);
        end
        in_valid4 = 1'b0; a4 = 4'h3; b4 = 4'hC; cin4 = 1'b0;
        exp[7] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({out_valid4, grp_p4, grp_g4, carry4, sum4} !== exp) begin
                errors++;
                $display("FAIL hold_idle[%0d]: got %h expected %h", i, {out_valid4, grp_p4, grp_g4, carry4, sum4}, exp);
            end
        end
    endtask

    task automatic test_reset_priority;
        a4 = 4'hE; b4 = 4'h7; cin4 = 1'b1; in_valid4 = 1'b1;
        @(posedge clk);
        #1;
        a4 = 4'hD; b4 = 4'h6; cin4 = 1'b1; rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid4, grp_p4, grp_g4, carry4, sum4} !== 8'h00) begin
            errors++;
            $display("FAIL reset_priority: got %h expected 00", {out_valid4, grp_p4, grp_g4, carry4, sum4});
        end
        rst_n = 1'b1; in_valid4 = 1'b0;
    endtask

    task automatic test_exhaustive;
        int bad = 0;
        logic [7:0] exp;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    a4 = 4'(x); b4 = 4'(y); cin4 = 1'(ci); in_valid4 = 1'b1;
                    @(posedge clk);
                    #1;
                    exp = {1'b1, ref4(4'(x), 4'(y), 1'(ci))};
                    checks++;
                    if ({out_valid4, grp_p4, grp_g4, carry4, sum4} !== exp) begin
                        errors++;
                        bad++;
                        if (bad <= 10)
                            $display("FAIL exhaustive a=%h b=%h cin=%0d: got %h expected %h",
                                     x, y, ci, {out_valid4, grp_p4, grp_g4, carry4, sum4}, exp);
                    end
                end
            end
        end
        in_valid4 = 1'b0;
    endtask

    task automatic test_wide;
        int bad = 0;
        logic [15:0] x;
        logic [15:0] y;
        logic        ci;
        logic [19:0] exp;
        for (int i = 0; i < 10002; i++) begin
            if (i == 0) begin
                x = 16'hFFFF; y = 16'h0001; ci = 1'b0;
            end else if (i == 1) begin
                x = 16'h1234; y = 16'h4321; ci = 1'b1;
            end else begin
                x = 16'($urandom); y = 16'($urandom); ci = 1'($urandom);
            end
            a16 = x; b16 = y; cin16 = ci; in_valid16 = 1'b1;
            @(posedge clk);
            #1;
            exp = {1'b1, ref16(x, y, ci)};
            checks++;
            if ({out_valid16, grp_p16, grp_g16, carry16, sum16} !== exp) begin
                errors++;
                bad++;
                if (bad <= 10)
                    $display("FAIL wide[%0d] a=%h b=%h cin=%b: got %h expected %h",
                             i, x, y, ci, {out_valid16, grp_p16, grp_g16, carry16, sum16}, exp);
            end
        end
        in_valid16 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_hold();
        test_reset_priority();
        test_exhaustive();
        test_wide();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
